// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: sigma constants, state type, FSM encoding,
// quarter-round and byte-swap helpers.
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  // 16 x 32-bit words; element i is state word i
  typedef logic [15:0][31:0] chacha_state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } qr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_OUT,
    S_DONE
  } chacha_fsm_t;

  function automatic logic [31:0] le_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] w, input int unsigned n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic qr_t quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
    qr_t r;
    r.a = a_in;
    r.b = b_in;
    r.c = c_in;
    r.d = d_in;
    r.a = r.a + r.b; r.d = rotl(r.d ^ r.a, 16);
    r.c = r.c + r.d; r.b = rotl(r.b ^ r.c, 12);
    r.a = r.a + r.b; r.d = rotl(r.d ^ r.a, 8);
    r.c = r.c + r.d; r.b = rotl(r.b ^ r.c, 7);
    return r;
  endfunction

endpackage

// File: rtl/chacha_round.sv
// One combinational ChaCha round: column round when diag=0, diagonal when diag=1.
module chacha_round
  import chacha_pkg::*;
(
  input  logic [511:0] state_in,
  input  logic         diag,
  output logic [511:0] state_out
);

  chacha_state_t st_in;
  chacha_state_t st_out;
  qr_t           qr [4];
  logic [3:0]    ib [4];
  logic [3:0]    ic [4];
  logic [3:0]    id [4];

  assign st_in     = state_in;
  assign state_out = st_out;

  // Diagonal rounds rotate rows 1..3 left by 1, 2, 3 words respectively
  for (genvar i = 0; i < 4; i++) begin : g_qr
    assign ib[i] = {2'b01, 2'(i) + {1'b0, diag}};
    assign ic[i] = {2'b10, 2'(i) + {diag, 1'b0}};
    assign id[i] = {2'b11, 2'(i) + {diag, diag}};
    assign qr[i] = quarter_round(st_in[i], st_in[ib[i]], st_in[ic[i]], st_in[id[i]]);
  end

  // Scatter the four quarter-round results back into their word slots
  always_comb begin
    st_out = st_in;
    for (int unsigned i = 0; i < 4; i++) begin
      st_out[i]     = qr[i].a;
      st_out[ib[i]] = qr[i].b;
      st_out[ic[i]] = qr[i].c;
      st_out[id[i]] = qr[i].d;
    end
  end

endmodule

// File: rtl/chacha_stream.sv
// ChaCha keystream generator: one request yields num_blocks consecutive
// 512-bit blocks over a valid/ready stream with an auto-incrementing counter.
module chacha_stream
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned RPC    = 1,
  parameter int unsigned NB_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [255:0]    key,
  input  logic [95:0]     nonce,
  input  logic [31:0]     counter,
  input  logic [NB_W-1:0] num_blocks,
  output logic [511:0]    out_data,
  output logic [31:0]     out_ctr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            ctr_wrap
);

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_stream: ROUNDS must be 8, 12 or 20");
  end
  if (!(RPC == 1 || RPC == 2) || (ROUNDS % RPC) != 0) begin : g_bad_rpc
    $error("chacha_stream: RPC must be 1 or 2 and divide ROUNDS");
  end

  chacha_fsm_t    state_q, state_d;
  logic [255:0]   key_q;
  logic [95:0]    nonce_q;
  logic [31:0]    ctr_q;
  logic [NB_W-1:0] rem_q;
  logic [4:0]     rnd_q;
  chacha_state_t  init_q, work_q, load_st;
  logic [511:0]   fin_data;
  logic [511:0]   chain [RPC+1];

  // Initial block state: sigma, key words, counter, nonce words
  assign load_st[0]  = SIGMA0;
  assign load_st[1]  = SIGMA1;
  assign load_st[2]  = SIGMA2;
  assign load_st[3]  = SIGMA3;
  assign load_st[12] = ctr_q;
  for (genvar j = 0; j < 8; j++) begin : g_key
    assign load_st[4+j] = le_word(key_q[255-32*j -: 32]);
  end
  for (genvar j = 0; j < 3; j++) begin : g_nonce
    assign load_st[13+j] = le_word(nonce_q[95-32*j -: 32]);
  end

  // Feed-forward addition and little-endian serialisation, word 0 first
  for (genvar i = 0; i < 16; i++) begin : g_fin
    assign fin_data[511-32*i -: 32] = le_word(work_q[i] + init_q[i]);
  end

  // Unrolled round chain; parity alternates column/diagonal along the chain
  assign chain[0] = work_q;
  for (genvar k = 0; k < RPC; k++) begin : g_chain
    chacha_round u_round (
      .state_in  (chain[k]),
      .diag      (rnd_q[0] ^ 1'(k % 2)),
      .state_out (chain[k+1])
    );
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_blocks == '0) ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_ROUND;
      S_ROUND: if (rnd_q == 5'(ROUNDS - RPC)) state_d = S_FINAL;
      S_FINAL: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = (rem_q == NB_W'(1)) ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q     <= '0;
      nonce_q   <= '0;
      ctr_q     <= '0;
      rem_q     <= '0;
      rnd_q     <= '0;
      init_q    <= '0;
      work_q    <= '0;
      out_data  <= '0;
      out_ctr   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ctr_wrap  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          key_q    <= key;
          nonce_q  <= nonce;
          ctr_q    <= counter;
          rem_q    <= num_blocks;
          busy     <= 1'b1;
          ctr_wrap <= 1'b0;
        end
        S_LOAD: begin
          init_q <= load_st;
          work_q <= load_st;
          rnd_q  <= '0;
        end
        S_ROUND: begin
          work_q <= chain[RPC];
          rnd_q  <= rnd_q + 5'(RPC);
        end
        S_FINAL: begin
          out_data  <= fin_data;
          out_ctr   <= ctr_q;
          out_valid <= 1'b1;
        end
        S_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          rem_q     <= rem_q - NB_W'(1);
          if (rem_q != NB_W'(1)) begin
            ctr_q <= ctr_q + 32'd1;
            if (ctr_q == '1) ctr_wrap <= 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
